// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer: sequencer state encoding
// and the activation width default used by the PE array layers.
`timescale 1ns/1ps
package fc_pkg;

  localparam int FC_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } fc_state_e;

  function automatic int fc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fc_down_counter.sv
// Loadable down-counter that saturates at zero; tc flags the terminal count.
`timescale 1ns/1ps
module fc_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/fc_layer_sequencer.sv
// Streams a captured activation vector to the PE array one element per cycle,
// highest index first, framed by an accumulator clear and a PE drain window.
`timescale 1ns/1ps
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH  = FC_DATA_WIDTH,
  parameter int INPUT_NODES = 128,
  parameter int PE_LATENCY  = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0]   input_fc,
  output logic [DATA_WIDTH-1:0]               selected_input,
  output logic                                elem_valid,
  output logic [$clog2(INPUT_NODES)-1:0]      elem_index,
  output logic                                pe_clear,
  output logic                                busy,
  output logic                                done,
  output logic [2:0]                          state
);

  localparam int IDX_W = $clog2(INPUT_NODES);
  localparam int CNT_W = fc_max(IDX_W, 4);
  localparam logic [CNT_W-1:0] STREAM_LOAD = CNT_W'(INPUT_NODES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'((PE_LATENCY > 0) ? PE_LATENCY - 1 : 0);

  fc_state_e                         st;
  logic [DATA_WIDTH*INPUT_NODES-1:0] shadow;
  logic [CNT_W-1:0]                  cnt;
  logic [CNT_W-1:0]                  next_cnt;
  logic [CNT_W-1:0]                  cnt_load_value;
  logic                              cnt_tc;
  logic                              cnt_load;
  logic                              cnt_en;

  // One counter serves both phases: it holds the index being presented in
  // STREAM and the remaining drain cycles in DRAIN.
  always_comb begin
    cnt_load       = 1'b0;
    cnt_load_value = STREAM_LOAD;
    cnt_en         = 1'b0;
    if (!abort) begin
      case (st)
        ST_CLEAR:  cnt_load = 1'b1;
        ST_STREAM: begin
          if (cnt_tc) begin
            cnt_load       = (PE_LATENCY > 0);
            cnt_load_value = DRAIN_LOAD;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_DRAIN:  cnt_en = !cnt_tc;
        default:   ;
      endcase
    end
  end

  fc_down_counter #(.WIDTH(CNT_W)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .en         (cnt_en),
    .count      (cnt),
    .tc         (cnt_tc)
  );

  assign next_cnt = cnt - CNT_W'(1);
  assign state    = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st             <= ST_IDLE;
      shadow         <= '0;
      selected_input <= '0;
      elem_valid     <= 1'b0;
      elem_index     <= '0;
      pe_clear       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else if (abort && (st != ST_IDLE)) begin
      st             <= ST_IDLE;
      selected_input <= '0;
      elem_valid     <= 1'b0;
      elem_index     <= '0;
      pe_clear       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start && !abort) begin
            shadow   <= input_fc;
            st       <= ST_CLEAR;
            pe_clear <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          st             <= ST_STREAM;
          pe_clear       <= 1'b0;
          elem_valid     <= 1'b1;
          elem_index     <= IDX_W'(INPUT_NODES - 1);
          selected_input <= shadow[DATA_WIDTH*(INPUT_NODES-1) +: DATA_WIDTH];
        end
        ST_STREAM: begin
          if (cnt_tc) begin
            elem_valid     <= 1'b0;
            selected_input <= '0;
            elem_index     <= '0;
            if (PE_LATENCY > 0) begin
              st <= ST_DRAIN;
            end else begin
              st   <= ST_DONE;
              done <= 1'b1;
            end
          end else begin
            elem_index     <= IDX_W'(next_cnt);
            selected_input <= shadow[DATA_WIDTH*int'(next_cnt) +: DATA_WIDTH];
          end
        end
        ST_DRAIN: begin
          if (cnt_tc) begin
            st   <= ST_DONE;
            done <= 1'b1;
          end
        end
        ST_DONE: begin
          st   <= ST_IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer: default build plus a 4-node,
// zero-latency build sharing the clock and reset.
`timescale 1ns/1ps
module tb_fc_layer_sequencer;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [1023:0] input_fc;
  logic [7:0]    selected_input;
  logic          elem_valid;
  logic [6:0]    elem_index;
  logic          pe_clear;
  logic          busy;
  logic          done;
  logic [2:0]    state_m;

  logic          start_s;
  logic          abort_s;
  logic [31:0]   input_fc_s;
  logic [7:0]    selected_input_s;
  logic          elem_valid_s;
  logic [1:0]    elem_index_s;
  logic          pe_clear_s;
  logic          busy_s;
  logic          done_s;
  logic [2:0]    state_s;

  logic [18:0]   obs;
  logic [13:0]   obs_s;

  int checks;
  int failures;

  assign obs   = {pe_clear, elem_valid, busy, done, elem_index, selected_input};
  assign obs_s = {pe_clear_s, elem_valid_s, busy_s, done_s, elem_index_s, selected_input_s};

  fc_layer_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .input_fc       (input_fc),
    .selected_input (selected_input),
    .elem_valid     (elem_valid),
    .elem_index     (elem_index),
    .pe_clear       (pe_clear),
    .busy           (busy),
    .done           (done),
    .state          (state_m)
  );

  fc_layer_sequencer #(.DATA_WIDTH(8), .INPUT_NODES(4), .PE_LATENCY(0)) dut_s (
    .clk            (clk),
    .reset          (reset),
    .start          (start_s),
    .abort          (abort_s),
    .input_fc       (input_fc_s),
    .selected_input (selected_input_s),
    .elem_valid     (elem_valid_s),
    .elem_index     (elem_index_s),
    .pe_clear       (pe_clear_s),
    .busy           (busy_s),
    .done           (done_s),
    .state          (state_s)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs of the default build, cycle k after the start edge,
  // with input element j = j+1.
  function automatic logic [18:0] exp_main(input int k);
    logic       pc, v, b, d;
    logic [6:0] idx;
    logic [7:0] s;
    pc = 1'b0; v = 1'b0; b = 1'b0; d = 1'b0; idx = '0; s = '0;
    if (k == 1) begin
      pc = 1'b1; b = 1'b1;
    end else if (k >= 2 && k <= 129) begin
      v = 1'b1; b = 1'b1; idx = 7'(129 - k); s = 8'(130 - k);
    end else if (k >= 130 && k <= 132) begin
      b = 1'b1;
    end else if (k == 133) begin
      b = 1'b1; d = 1'b1;
    end
    return {pc, v, b, d, idx, s};
  endfunction

  function automatic logic [13:0] exp_small(input int k);
    logic       pc, v, b, d;
    logic [1:0] idx;
    logic [7:0] s;
    pc = 1'b0; v = 1'b0; b = 1'b0; d = 1'b0; idx = '0; s = '0;
    if (k == 1) begin
      pc = 1'b1; b = 1'b1;
    end else if (k >= 2 && k <= 5) begin
      v = 1'b1; b = 1'b1; idx = 2'(5 - k); s = 8'(6 - k);
    end else if (k == 6) begin
      b = 1'b1; d = 1'b1;
    end
    return {pc, v, b, d, idx, s};
  endfunction

  // Driver tasks
  task automatic load_ramp();
    for (int j = 0; j < 128; j++) input_fc[8*j +: 8] = 8'(j + 1);
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    start_s = 1'b0; abort_s = 1'b0;
    input_fc = '0; input_fc_s = '0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 19'd0 || state_m !== 3'd0) begin
      failures++;
      $display("FAIL reset_async: got %h state %0d, expected 0 state 0", obs, state_m);
    end
    checks++;
    if (obs_s !== 14'd0) begin
      failures++;
      $display("FAIL reset_async_small: got %h expected 0", obs_s);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 19'd0) begin
      failures++;
      $display("FAIL reset_idle: got %h expected 0", obs);
    end
  endtask

  task automatic test_stream();
    logic [18:0] e;
    load_ramp();
    launch();
    for (int k = 1; k <= 136; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      e = exp_main(k);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL stream cycle %0d: got %h expected %h", k, obs, e);
      end
      if (k == 5) input_fc = '1;
    end
  endtask

  task automatic test_start_held();
    logic [18:0] e;
    load_ramp();
    launch();
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      e = (k <= 134) ? exp_main(k) : exp_main(k - 134);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL start_held cycle %0d: got %h expected %h", k, obs, e);
      end
    end
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (obs !== 19'd0 || state_m !== 3'd0) begin
      failures++;
      $display("FAIL start_held_abort: got %h state %0d expected 0 state 0", obs, state_m);
    end
  endtask

  task automatic test_abort();
    logic [18:0] e;
    load_ramp();
    launch();
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      e = (k <= 50) ? exp_main(k) : 19'd0;
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abort cycle %0d: got %h expected %h", k, obs, e);
      end
      if (k == 50) abort = 1'b1;
      if (k == 51) abort = 1'b0;
    end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (obs !== 19'd0 || state_m !== 3'd0) begin
      failures++;
      $display("FAIL abort_start_idle: got %h state %0d expected 0 state 0", obs, state_m);
    end
  endtask

  task automatic test_reset_mid();
    logic [18:0] e;
    load_ramp();
    launch();
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      e = (k <= 70) ? exp_main(k) : 19'd0;
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", k, obs, e);
      end
      if (k == 70) begin
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 19'd0 || state_m !== 3'd0) begin
          failures++;
          $display("FAIL reset_mid_async: got %h state %0d expected 0 state 0", obs, state_m);
        end
      end
      if (k == 72) reset = 1'b1;
    end
    test_stream();
  endtask

  task automatic test_small_no_drain();
    logic [13:0] e;
    input_fc_s = {8'd4, 8'd3, 8'd2, 8'd1};
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) start_s = 1'b0;
      e = exp_small(k);
      checks++;
      if (obs_s !== e || state_s === 3'd3) begin
        failures++;
        $display("FAIL small cycle %0d: got %h state %0d expected %h", k, obs_s, state_s, e);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_start_held();
    test_abort();
    test_reset_mid();
    test_small_no_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
